// File: rtl/comparator_serial_param_pkg.sv
// Shared types and result decode for comparator_serial_param.
// Optional feature macro (used by the top): CMP_EARLY_EXIT_EN.
package cmp_pkg;

  // Relation codes, values match the in_op encoding; 3'b110/3'b111 are reserved.
  typedef enum logic [2:0] {
    EQ = 3'b000,
    NE = 3'b001,
    LT = 3'b010,
    LE = 3'b011,
    GT = 3'b100,
    GE = 3'b101
  } cmp_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } cmp_state_e;

  // Map the sticky lt/gt scan outcome to {res, err} for the requested relation.
  function automatic logic [1:0] cmp_apply(input logic [2:0] op, input logic lt, input logic gt);
    logic       eq;
    logic [1:0] r;
    eq = !lt && !gt;
    r  = 2'b01;
    case (op)
      EQ:      r = {eq, 1'b0};
      NE:      r = {!eq, 1'b0};
      LT:      r = {lt, 1'b0};
      LE:      r = {lt | eq, 1'b0};
      GT:      r = {gt, 1'b0};
      GE:      r = {gt | eq, 1'b0};
      default: r = 2'b01;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/comparator_serial_param_if.sv
// Request/response bus of comparator_serial_param.
interface comparator_serial_param_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             in_signed;
  logic             out_valid;
  logic             out_ready;
  logic             out_res;
  logic             out_err;

  modport master (
    output in_valid, in_a, in_b, in_op, in_signed, out_ready,
    input  in_ready, out_valid, out_res, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_signed, out_ready,
    output in_ready, out_valid, out_res, out_err
  );
endinterface

// File: rtl/comparator_serial_param_digit.sv
// Single-digit unsigned magnitude compare used by the serial scan.
module cmp_digit #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  output logic             d_lt,
  output logic             d_gt
);

  assign d_lt = (a_d < b_d);
  assign d_gt = (a_d > b_d);

endmodule

// File: rtl/comparator_serial_param.sv
// Digit-serial magnitude comparator, MSB-first, DIGIT bits per SCAN cycle.
// Define CMP_EARLY_EXIT_EN to leave SCAN as soon as the outcome is decided
// (data-dependent latency; only for public operands).
module comparator_serial_param
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input logic                     clk,
  input logic                     rst,
  comparator_serial_param_if.slave bus
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("comparator_serial_param: WIDTH must be >= 2");
  end
  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("comparator_serial_param: WIDTH must be a multiple of DIGIT");
  end

  cmp_state_e       state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic             lt_q, gt_q;
  logic             res_q, err_q;
  logic             in_ready_q, out_valid_q;

  logic [CW-1:0]    idx;
  logic [DIGIT-1:0] a_dig, b_dig;
  logic             d_lt, d_gt;
  logic             lt_d, gt_d;
  logic             last_d;

  // Select the digit under examination: index N-1-cnt, i.e. MSB digit first.
  always_comb begin
    idx   = CNT_LAST - cnt_q;
    a_dig = a_q[idx*DIGIT +: DIGIT];
    b_dig = b_q[idx*DIGIT +: DIGIT];
  end

  cmp_digit #(.DIGIT(DIGIT)) u_digit (
    .a_d  (a_dig),
    .b_d  (b_dig),
    .d_lt (d_lt),
    .d_gt (d_gt)
  );

  // Sticky decision: the first differing digit settles lt/gt; later digits are ignored.
  always_comb begin
    lt_d = lt_q | (!lt_q && !gt_q && d_lt);
    gt_d = gt_q | (!lt_q && !gt_q && d_gt);
`ifdef CMP_EARLY_EXIT_EN
    last_d = (cnt_q == CNT_LAST) || lt_d || gt_d;
`else
    last_d = (cnt_q == CNT_LAST);
`endif
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      lt_q        <= 1'b0;
      gt_q        <= 1'b0;
      res_q       <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            // Flipping the sign bit maps two's-complement order onto unsigned order.
            a_q        <= bus.in_a ^ {bus.in_signed, {(WIDTH-1){1'b0}}};
            b_q        <= bus.in_b ^ {bus.in_signed, {(WIDTH-1){1'b0}}};
            op_q       <= bus.in_op;
            cnt_q      <= '0;
            lt_q       <= 1'b0;
            gt_q       <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= SCAN;
          end
        end
        SCAN: begin
          lt_q  <= lt_d;
          gt_q  <= gt_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_d) begin
            {res_q, err_q} <= cmp_apply(op_q, lt_d, gt_d);
            out_valid_q    <= 1'b1;
            state_q        <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_res   = res_q;
  assign bus.out_err   = err_q;

endmodule
